// File: rtl/seq_alu_pkg.sv
// seq_alu_pkg: shared widths, opcode and issuer state types for the sequential ALU issue stage
package seq_alu_pkg;
  localparam int OPND_W = 4;
  localparam int RES_W = 5;
  typedef enum logic [1:0] {ALU_ADD = 2'b00, ALU_SUB, ALU_AND, ALU_OR} alu_op_e;
  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_CAPTURE, ST_RESULT} issue_state_e;
endpackage

// File: rtl/alu_cmd_fifo.sv
// alu_cmd_fifo: synchronous command FIFO, power-of-two DEPTH, push/pop/full/empty
module alu_cmd_fifo #(
  parameter int W = 13,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  always_comb begin
    wr_d = wr_q + AW'(push);
    rd_d = rd_q + AW'(pop);
    cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
    if (push) mem_q[wr_q] <= din;
  end
  assign dout = mem_q[rd_q];
  assign full = cnt_q == (AW+1)'(DEPTH);
  assign empty = cnt_q == '0;
endmodule

// File: rtl/seq_alu_issuer.sv
// seq_alu_issuer: buffers ALU commands, issues one at a time, returns tagged results.
// Define ALU_ISSUE_STATS_EN to add saturating issued_cnt/stall_cnt outputs.
module seq_alu_issuer
  import seq_alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic signed [OPND_W-1:0] cmd_a,
  input  logic signed [OPND_W-1:0] cmd_b,
  input  logic [1:0]               cmd_op,
  input  logic [TAG_W-1:0]         cmd_tag,
  output logic                     alu_en,
  output logic signed [OPND_W-1:0] alu_a,
  output logic signed [OPND_W-1:0] alu_b,
  output logic [1:0]               alu_op,
  input  logic signed [RES_W-1:0]  alu_c,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic signed [RES_W-1:0]  res_c,
  output logic [TAG_W-1:0]         res_tag
`ifdef ALU_ISSUE_STATS_EN
  ,
  output logic [15:0]              issued_cnt,
  output logic [15:0]              stall_cnt
`endif
);
  localparam int W = 2 * OPND_W + 2 + TAG_W;
  issue_state_e state_q, state_d;
  logic signed [OPND_W-1:0] a_q, a_d, b_q, b_d;
  alu_op_e op_q, op_d;
  logic [TAG_W-1:0] tag_q, tag_d, res_tag_q, res_tag_d;
  logic signed [RES_W-1:0] res_c_q, res_c_d;
  logic push, pop, full, empty;
  logic [W-1:0] head;
  alu_cmd_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(push), .pop(pop),
    .din({cmd_a, cmd_b, cmd_op, cmd_tag}), .dout(head), .full(full), .empty(empty)
  );
  assign cmd_ready = !full;
  assign push = cmd_valid && !full;
  always_comb begin
    pop = (state_q == ST_IDLE || (state_q == ST_RESULT && res_ready)) && !empty;
    state_d = state_q == ST_IDLE    ? (pop ? ST_ISSUE : ST_IDLE)
            : state_q == ST_ISSUE   ? ST_CAPTURE
            : state_q == ST_CAPTURE ? ST_RESULT
            : res_ready ? (empty ? ST_IDLE : ST_ISSUE) : ST_RESULT;
    a_d = pop ? head[TAG_W+2+OPND_W +: OPND_W] : a_q;
    b_d = pop ? head[TAG_W+2 +: OPND_W] : b_q;
    op_d = pop ? alu_op_e'(head[TAG_W +: 2]) : op_q;
    tag_d = pop ? head[TAG_W-1:0] : tag_q;
    res_c_d = state_q == ST_CAPTURE ? alu_c : res_c_q;
    res_tag_d = state_q == ST_CAPTURE ? tag_q : res_tag_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q <= '0;
      b_q <= '0;
      op_q <= ALU_ADD;
      tag_q <= '0;
      res_c_q <= '0;
      res_tag_q <= '0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      op_q <= op_d;
      tag_q <= tag_d;
      res_c_q <= res_c_d;
      res_tag_q <= res_tag_d;
    end
  end
  assign alu_en = state_q == ST_ISSUE;
  assign alu_a = a_q;
  assign alu_b = b_q;
  assign alu_op = op_q;
  assign res_valid = state_q == ST_RESULT;
  assign res_c = res_c_q;
  assign res_tag = res_tag_q;
`ifdef ALU_ISSUE_STATS_EN
  logic [15:0] issued_q, issued_d, stall_q, stall_d;
  always_comb begin
    issued_d = issued_q + 16'(alu_en && issued_q != 16'hFFFF);
    stall_d = stall_q + 16'(res_valid && !res_ready && stall_q != 16'hFFFF);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      issued_q <= '0;
      stall_q <= '0;
    end else begin
      issued_q <= issued_d;
      stall_q <= stall_d;
    end
  end
  assign issued_cnt = issued_q;
  assign stall_cnt = stall_q;
`endif
endmodule

// File: tb/tb_seq_alu_issuer.sv
// tb_seq_alu_issuer: directed scoreboard bench for seq_alu_issuer with a registered ALU model
module tb_seq_alu_issuer;
  import seq_alu_pkg::*;
  logic clk = 0, rst = 1, cmd_valid = 0, res_ready = 0;
  logic cmd_ready, alu_en, res_valid;
  logic signed [3:0] cmd_a = 0, cmd_b = 0, alu_a, alu_b;
  logic [1:0] cmd_op = 0, alu_op;
  logic [2:0] cmd_tag = 0, res_tag;
  logic signed [4:0] alu_c, res_c;
`ifdef ALU_ISSUE_STATS_EN
  logic [15:0] issued_cnt, stall_cnt;
`endif
  seq_alu_issuer #(.DEPTH(4), .TAG_W(3)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_tag(cmd_tag),
    .alu_en(alu_en), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_c(alu_c),
    .res_valid(res_valid), .res_ready(res_ready), .res_c(res_c), .res_tag(res_tag)
`ifdef ALU_ISSUE_STATS_EN
    , .issued_cnt(issued_cnt), .stall_cnt(stall_cnt)
`endif
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  // Registered ALU: result appears the cycle after alu_en
  always @(posedge clk) begin
    if (rst) alu_c <= '0;
    else if (alu_en)
      case (alu_op)
        2'b00: alu_c <= {alu_a[3], alu_a} + {alu_b[3], alu_b};
        2'b01: alu_c <= {alu_a[3], alu_a} - {alu_b[3], alu_b};
        2'b10: alu_c <= {alu_a[3], alu_a} & {alu_b[3], alu_b};
        default: alu_c <= {alu_a[3], alu_a} | {alu_b[3], alu_b};
      endcase
  end
  typedef struct {int c; int tag;} exp_t;
  exp_t exp_q[$];
  exp_t e_m;
  int n_cmp = 0, n_bad = 0, prev_cyc = 0;
  bit space_en = 0, have_prev = 0;
  function automatic void chk(string name, int act, int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endfunction
  function automatic void timeout(string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endfunction
  always @(negedge clk) begin
    if (!rst && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_result: got c=%0d tag=%0d, required none", res_c, res_tag);
      end else begin
        e_m = exp_q.pop_front();
        chk("res_c", res_c, e_m.c);
        chk("res_tag", res_tag, e_m.tag);
      end
      if (space_en && have_prev) chk("result_spacing", cyc - prev_cyc, 3);
      have_prev = 1;
      prev_cyc = cyc;
    end
  end
  task automatic send(input int a, input int b, input int op, input int tag, input int c, input bit keep);
    int n = 0;
    cmd_a = 4'(a);
    cmd_b = 4'(b);
    cmd_op = 2'(op);
    cmd_tag = 3'(tag);
    cmd_valid = 1;
    do begin
      @(negedge clk);
      n++;
    end while (!cmd_ready && n < 300);
    if (!cmd_ready) timeout("cmd_accept");
    @(posedge clk);
    #1;
    if (keep) exp_q.push_back('{c, tag});
  endtask
  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) timeout("drain");
    repeat (3) @(posedge clk);
    #1;
  endtask
  initial begin
    int ens, n;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_alu_en", alu_en, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_alu_op", alu_op, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_c", res_c, 0);
    chk("rst_res_tag", res_tag, 0);
    @(posedge clk);
    #1 rst = 0;
    res_ready = 1;
    send(3, 4, ALU_ADD, 1, 7, 1);
    cmd_valid = 0;
    @(negedge clk) chk("e0_alu_en", alu_en, 0);
    @(negedge clk) chk("e1_alu_en", alu_en, 1);
    chk("e1_alu_a", alu_a, 3);
    chk("e1_alu_b", alu_b, 4);
    chk("e1_alu_op", alu_op, 0);
    @(negedge clk) chk("e2_alu_en", alu_en, 0);
    chk("e2_res_valid", res_valid, 0);
    @(negedge clk) chk("e3_res_valid", res_valid, 1);
    drain();
    send(-8, 1, ALU_SUB, 2, -9, 1);
    send(-1, 5, ALU_AND, 3, 5, 1);
    send(-6, 5, ALU_OR, 4, -1, 1);
    cmd_valid = 0;
    drain();
    res_ready = 0;
    send(1, 1, ALU_ADD, 0, 2, 1);
    send(2, 5, ALU_SUB, 1, -3, 1);
    send(7, 7, ALU_ADD, 2, 14, 1);
    send(-8, 7, ALU_OR, 3, -1, 1);
    send(6, 3, ALU_AND, 4, 2, 1);
    cmd_tag = 3'd5;
    repeat (3) begin
      @(negedge clk);
      chk("full_cmd_ready", cmd_ready, 0);
      chk("full_res_valid", res_valid, 1);
      chk("full_res_tag", res_tag, 0);
    end
    @(posedge clk);
    #1 cmd_valid = 0;
    res_ready = 1;
    drain();
    space_en = 1;
    have_prev = 0;
    for (int i = 0; i < 8; i++) send(i, 1, ALU_ADD, i, i + 1, 1);
    cmd_valid = 0;
    drain();
    space_en = 0;
    send(1, 2, ALU_ADD, 5, 0, 0);
    send(3, 3, ALU_ADD, 6, 0, 0);
    send(2, 2, ALU_ADD, 7, 0, 0);
    rst = 1;
    cmd_valid = 0;
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("post_rst_res_valid", res_valid, 0);
    chk("post_rst_cmd_ready", cmd_ready, 1);
    chk("post_rst_alu_en", alu_en, 0);
    ens = 0;
    repeat (8) begin
      @(negedge clk);
      ens += int'(alu_en) + int'(res_valid);
    end
    chk("post_rst_no_issue", ens, 0);
`ifdef ALU_ISSUE_STATS_EN
    res_ready = 0;
    send(1, 1, ALU_ADD, 1, 2, 1);
    send(2, 2, ALU_ADD, 2, 4, 1);
    send(3, 3, ALU_ADD, 3, 6, 1);
    cmd_valid = 0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!res_valid && n < 50);
    if (!res_valid) timeout("stats_res_valid");
    repeat (4) @(posedge clk);
    #1 res_ready = 1;
    drain();
    chk("issued_cnt", issued_cnt, 3);
    chk("stall_cnt", stall_cnt, 4);
`else
    n = 0;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
endmodule

// File: doc/seq_alu_issuer.md
# seq_alu_issuer

Command issue stage directly upstream of the sequential ALU. It accepts operand/opcode commands over a valid/ready interface and buffers them in a small FIFO. It drives the ALU's enable, operand and opcode inputs one command at a time, captures the ALU's registered 5-bit result, and returns it with the command's tag over a valid/ready result interface.

## Interface
- DEPTH, 4, command FIFO entries; power of two, ≥2
- TAG_W, 3, width of the command tag returned with the result
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset: synchronous, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  FIFO can accept (high when not full)
- cmd_a  in  4  signed operand A
- cmd_b  in  4  signed operand B
- cmd_op  in  2  opcode: 00 add, 01 sub, 10 and, 11 or
- cmd_tag  in  TAG_W  caller tag
- alu_en  out  1  ALU enable, one-cycle pulse per command
- alu_a, alu_b  out  4  signed operands to ALU
- alu_op  out  2  opcode to ALU
- alu_c  in  5  signed registered ALU result
- res_valid  out  1  result held
- res_ready  in  1  consumer accepts result
- res_c  out  5  signed result
- res_tag  out  TAG_W  tag of the command that produced res_c

## Operation
- Push on cmd_valid && cmd_ready. cmd_ready = !full; it does not depend on a same-cycle pop, so there is no pass-through when full.
- FSM states IDLE, ISSUE, CAPTURE, RESULT:
  - IDLE: if FIFO is non-empty, pop the head into the operand/tag registers and go to ISSUE.
  - ISSUE: alu_en=1 for exactly this cycle; go to CAPTURE.
  - CAPTURE: alu_c is valid. Register res_c<=alu_c and res_tag<=the held tag; go to RESULT.
  - RESULT: res_valid=1, and res_c/res_tag are stable until the handshake. On res_valid && res_ready: if the FIFO is non-empty, pop and go to ISSUE; else go to IDLE.
- Only one command is in flight. alu_a, alu_b and alu_op are held from the pop until the next pop.
- Opcode is passed through unchanged. No arithmetic is done in this block; the width rules are the ALU's (5-bit signed sum/difference, sign-extended bitwise).
- Push and pop in the same cycle is legal at any occupancy below full. Pointers wrap modulo DEPTH. The count saturates at neither end, because the handshake rules prevent overflow and underflow.

## Timing
- Reset values: cmd_ready=1, alu_en=0, alu_a=0, alu_b=0, alu_op=0, res_valid=0, res_c=0, res_tag=0, FSM in IDLE, FIFO empty.
- Command accepted at edge E0 into an empty FIFO with the FSM idle:
  - pop at E1, alu_en high in cycle E1–E2
  - ALU captures at E2
  - res_valid high from E3
- With res_ready tied high, throughput is one result per 3 cycles.
- rst asserted mid-operation clears everything at that edge:
  - the FIFO is flushed and the in-flight command is discarded
  - res_valid drops the cycle after rst and no partial result is produced
- The ALU's own reset is its inverted rst at top level. No issue occurs before the first edge after rst deasserts.

## Configuration
- ALU_ISSUE_STATS_EN defined: adds output ports issued_cnt[15:0] and stall_cnt[15:0].
  - issued_cnt increments in each alu_en cycle.
  - stall_cnt increments in each cycle with res_valid && !res_ready.
  - Both saturate at 16'hFFFF and reset to 0.
- Not defined: the counters and their ports are absent, with no other behavioural difference.

## Structure
- Package seq_alu_pkg:
  - OPND_W=4, RES_W=5
  - alu_op_e enum (ALU_ADD=2'b00, ALU_SUB, ALU_AND, ALU_OR)
  - issuer state enum
- One sub-module: alu_cmd_fifo, a parameterised synchronous FIFO with push/pop/full/empty over {a,b,op,tag}. The FSM, result registers and stats stay in seq_alu_issuer.

## Test plan
- ADD a=3, b=4, tag=1, res_ready=1 → alu_en is one pulse at E1; res_c=7, res_tag=1, res_valid at E3.
- SUB a=-8, b=1 → res_c=-9 (5'b10111); AND a=-1, b=5 → res_c=5; OR a=4'b1010, b=4'b0101 → res_c=-1 (5'b11111).
- res_ready=0, push 6 commands back-to-back → 5 accepted (1 in RESULT, 4 in FIFO), cmd_ready low at the 6th. Release res_ready → results come out in order with correct tags.
- Stream 8 commands with res_ready=1 → results spaced every 3 cycles and FIFO pointers wrap. Push and pop in the same cycle keeps the count constant.
- rst pulse while in CAPTURE with 2 queued → next cycle res_valid=0, cmd_ready=1, no alu_en. The queued commands are never issued.
- ALU_ISSUE_STATS_EN: 3 commands with res_ready held low 4 cycles on the first → issued_cnt=3, stall_cnt=4.
